// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier: (a * b) mod q by MSB-first double-and-add,
// one multiplier bit per cycle, with valid/ready handshakes on both sides.
module mod_mul_seq #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_q,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_res,
    output logic         busy
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          in_fire;
    logic          out_fire;
    logic          last_bit;
    logic [W:0]    t_dbl;
    logic [W:0]    t_red;
    logic [W:0]    u_sum;
    logic [W-1:0]  acc_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire)  state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready is gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        in_ready  = (state_q == IDLE) && rst_n;
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_res   = res_q;
    end

    always_comb begin
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        last_bit = (cnt_q == '0);
    end

    // W+1-bit intermediates keep 2*acc and t+a exact for any q < 2^W.
    always_comb begin
        t_dbl = {acc_q, 1'b0};
        t_red = (t_dbl >= {1'b0, q_q}) ? (t_dbl - {1'b0, q_q}) : t_dbl;
        u_sum = b_q[cnt_q] ? (t_red + {1'b0, a_q}) : t_red;
        acc_step = (u_sum >= {1'b0, q_q}) ? W'(u_sum - {1'b0, q_q}) : u_sum[W-1:0];
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        q_d   = q_q;
        acc_d = acc_q;
        res_d = res_q;
        cnt_d = cnt_q;
        if (state_q == IDLE && in_fire) begin
            a_d   = in_a;
            b_d   = in_b;
            q_d   = in_q;
            acc_d = '0;
            cnt_d = CW'(W - 1);
        end else if (state_q == RUN) begin
            acc_d = acc_step;
            cnt_d = cnt_q - CW'(1);
            if (last_bit) begin
                res_d = acc_step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            q_q   <= '0;
            acc_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            q_q   <= q_d;
            acc_q <= acc_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mod_mul_seq.sv
// Directed bench for mod_mul_seq: reset values, latency, arithmetic corner
// cases, backpressure, mid-run reset, and a short randomized sweep.
module tb_mod_mul_seq;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] in_q = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_res;
    logic         busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mod_mul_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake an operand set, then scramble the inputs; returns at edge T + 1ns.
    task automatic start_op(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] q);
        int n = 0;
        while (in_ready !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " in_ready"}, in_ready, 1);
        in_a = a; in_b = b; in_q = q; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        in_q = {$urandom, $urandom};
        chk({tag, " busy"}, busy, 1);
        chk({tag, " in_ready_run"}, in_ready, 0);
    endtask

    // Wait for out_valid; it must appear exactly W edges after the accept edge.
    task automatic wait_done(input string tag, input bit check_lat);
        int n = 0;
        while (out_valid !== 1'b1 && n < W + 20) begin
            @(posedge clk); #1;
            n++;
            if (check_lat && n < W) chk({tag, " early_valid"}, out_valid, 0);
        end
        if (check_lat) chk({tag, " latency"}, n, W);
        else           chk({tag, " timeout"}, out_valid, 1);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " valid_drop"}, out_valid, 0);
        chk({tag, " idle"}, busy, 0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] exp);
        start_op(tag, a, b, q);
        wait_done(tag, 1'b1);
        chk({tag, " res"}, out_res, exp);
        finish_op(tag);
    endtask

    initial begin
        logic [W-1:0]   ra, rb, rq, rexp;
        logic [2*W-1:0] prod;
        bit             seen;

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst out_res", out_res, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst in_ready", in_ready, 1);

        run_op("s1", 64'd5, 64'd7, 64'd17, 64'd1);

        run_op("s2a", 64'hFFFF_FFFF_FFFF_FFC4, 64'hFFFF_FFFF_FFFF_FFC4,
               64'hFFFF_FFFF_FFFF_FFC5, 64'd1);
        run_op("s2b", 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFC5, 64'd59);

        run_op("s3a", 64'd50, 64'd0, 64'd97, 64'd0);
        run_op("s3b", 64'd0, 64'd0, 64'd1, 64'd0);
        run_op("s3c", 64'd0, 64'd33, 64'd97, 64'd0);

        // Backpressure: result held for 10 cycles, new input ignored.
        out_ready = 1'b0;
        start_op("s4", 64'd50, 64'd3, 64'd97);
        wait_done("s4", 1'b1);
        in_valid = 1'b1;
        in_a = 64'd1; in_b = 64'd1; in_q = 64'd5;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("s4 hold_valid", out_valid, 1);
            chk("s4 hold_res", out_res, 64'd53);
            chk("s4 hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        finish_op("s4");
        chk("s4 in_ready_back", in_ready, 1);
        chk("s4 res_kept", out_res, 64'd53);

        // Reset at RUN cycle 20: aborted result must never appear.
        start_op("s5", 64'd9, 64'd11, 64'd1000);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s5 rst busy", busy, 0);
        chk("s5 rst in_ready", in_ready, 0);
        chk("s5 rst out_valid", out_valid, 0);
        chk("s5 rst out_res", out_res, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < W + 5; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        chk("s5 no_stale_result", seen, 0);
        run_op("s5", 64'd4, 64'd6, 64'd13, 64'd11);

        // Randomized operands with random input gaps and output stalls.
        for (int i = 0; i < 150; i++) begin
            rq = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
            if (rq == '0) rq = 64'd1;
            ra = {$urandom, $urandom} % rq;
            rb = {$urandom, $urandom} % rq;
            prod = ra * rb;
            rexp = W'(prod % {64'd0, rq});
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            out_ready = 1'b0;
            start_op("rnd", ra, rb, rq);
            wait_done("rnd", 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            chk("rnd res", out_res, rexp);
            finish_op("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
